fill_row_engine: RTL
====================

Name: fill_row_engine

Overview:
- Responder side of the fill controller's fill_start/fill_done handshake.
- On a fill_start pulse it latches one row span (y, x_left..x_right) and a fill colour.
- It writes that colour to every pixel of the span through a req/ack framebuffer write port, then pulses fill_done.
- Sits between the fill controller / row reader and the SRAM write arbiter.

Parameters:
- SCREEN_W, 640, pixels per row; row stride for address generation.
- SCREEN_H, 480, rows per frame.
- X_W, 10, width of x coordinates.
- Y_W, 9, width of y coordinates.
- ADDR_W, 19, framebuffer pixel address width; must satisfy SCREEN_W*SCREEN_H <= 2^ADDR_W.
- COLOR_W, 8, pixel colour width.

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- fill_start  in  1  single-cycle start pulse from the fill controller.
- row_valid  in  1  the row reader found a span on this row; 0 means empty row.
- row_y  in  Y_W  row index.
- x_left  in  X_W  span start, inclusive.
- x_right  in  X_W  span end, inclusive.
- fill_color  in  COLOR_W  colour to write.
- mem_wr_req  out  1  write request; held until acked.
- mem_addr  out  ADDR_W  pixel address = y*SCREEN_W + x.
- mem_wdata  out  COLOR_W  latched fill colour.
- mem_ack  in  1  write accepted this cycle (sampled only while mem_wr_req=1).
- busy  out  1  high in every state except IDLE.
- fill_done  out  1  single-cycle completion pulse.
- pix_count  out  X_W+1  pixels written for the last span; held until the next fill_start.

Behaviour:
- Clocking and reset: one clock domain; n_rst asynchronous active-low.
- Reset values: state=IDLE; mem_wr_req=0, mem_addr=0, mem_wdata=0, busy=0, fill_done=0, pix_count=0.
- Reset mid-operation abandons the span immediately: no pending write, no fill_done.
- States: IDLE, SETUP, WRITE, DONE.
- IDLE:
  - On fill_start, latch row_y, x_left, fill_color.
  - Latch x_end = min(x_right, SCREEN_W-1).
  - Clear pix_count.
  - Span is empty if row_valid=0, or x_left>x_end, or x_left>=SCREEN_W, or row_y>=SCREEN_H.
  - Empty span -> DONE; otherwise -> SETUP.
- SETUP (1 cycle): register mem_addr = row_y*SCREEN_W + x_left (the multiply is done only here); x_cur=x_left; -> WRITE.
- WRITE:
  - mem_wr_req=1; mem_addr and mem_wdata stable while unacked.
  - On mem_ack: pix_count+1.
  - If x_cur==x_end -> DONE.
  - Else x_cur+1 and mem_addr+1, staying in WRITE with req held high, so back-to-back acks give one pixel per cycle.
- DONE: fill_done=1 for exactly one cycle; mem_wr_req=0; -> IDLE.
- Latency:
  - Non-empty span of N pixels with mem_ack tied high: fill_start at cycle 0, first req at cycle 2, fill_done at cycle N+2.
  - Empty span: fill_done at cycle 1.
- fill_start while busy is ignored; latched values are not disturbed.
- Input span fields are don't-care outside the fill_start cycle.
- Address arithmetic is unsigned, computed at ADDR_W width, never wraps within the frame.
- x_cur counts at X_W+1 bits so x_end=SCREEN_W-1 terminates correctly.
- mem_ack while mem_wr_req=0 is ignored.

Decomposition:
- Shared package gpu_fill_pkg holds:
  - state enum fill_row_state_t (IDLE, SETUP, WRITE, DONE);
  - SCREEN_W and SCREEN_H defaults;
  - colour and address width constants, also used by fill_controller and the SRAM arbiter.
- Single module; span clamp/empty test is inline combinational logic. No sub-module.

Test Plan:
- Span y=2, x 10..13, colour 0x5A, ack tied 1 -> addresses 1290,1291,1292,1293 on cycles 2..5 with wdata 0x5A; fill_done at cycle 6; pix_count=4.
- Same span, ack delayed 3 cycles per pixel -> each address held stable until acked; no skipped or duplicate writes; fill_done one cycle after 4th ack.
- row_valid=0, or x_left=20/x_right=5 -> no mem_wr_req ever; fill_done at cycle 1; pix_count=0.
- y=479, x 630..700 -> clamped to 630..639; last address 307199; pix_count=10.
- Second fill_start during WRITE, then n_rst low mid-span -> second start ignored; after reset mem_wr_req=0, busy=0, no fill_done; a new span then completes normally.

Source files
------------

// File: rtl/gpu_fill_pkg.sv
// Shared definitions for the GPU fill path.
// Holds the row-engine state encoding, the default screen geometry, and the
// colour/address widths. fill_controller and the SRAM write arbiter use the
// same width constants so the framebuffer write port agrees on every side.
package gpu_fill_pkg;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int X_W_DEF      = 10;
  localparam int Y_W_DEF      = 9;
  localparam int ADDR_W_DEF   = 19;
  localparam int COLOR_W_DEF  = 8;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_SETUP = 2'd1,
    FR_WRITE = 2'd2,
    FR_DONE  = 2'd3
  } fill_row_state_t;

endpackage

// File: rtl/fill_row_engine.sv
// fill_row_engine: writes one horizontal span of a single colour into the
// framebuffer, one pixel per accepted write request.
//
// Ports:
//   clk, n_rst            clock (rising edge), async active-low reset
//   fill_start            single-cycle start pulse, honoured only when idle
//   row_valid             0 = the row reader found no span on this row
//   row_y, x_left/x_right span row and inclusive x range (sampled with fill_start)
//   fill_color            colour written to every pixel of the span
//   mem_wr_req/mem_ack    framebuffer write handshake; req held until acked
//   mem_addr/mem_wdata    pixel address (y*SCREEN_W + x) and colour
//   busy                  high whenever the engine is not idle
//   fill_done             one-cycle completion pulse
//   pix_count             pixels written for the last span
module fill_row_engine
  import gpu_fill_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int X_W      = X_W_DEF,
  parameter int Y_W      = Y_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int COLOR_W  = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_start,
  input  logic               row_valid,
  input  logic [Y_W-1:0]     row_y,
  input  logic [X_W-1:0]     x_left,
  input  logic [X_W-1:0]     x_right,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  output logic               busy,
  output logic               fill_done,
  output logic [X_W:0]       pix_count
);

  // Geometry limits widened by one bit so comparisons never truncate.
  localparam logic [X_W:0] X_LAST_C  = (X_W+1)'(SCREEN_W - 1);
  localparam logic [X_W:0] X_LIMIT_C = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_LIMIT_C = (Y_W+1)'(SCREEN_H);

  fill_row_state_t    state_r, state_next_s;
  logic [Y_W-1:0]     y_r, y_next_s;
  logic [X_W:0]       x_cur_r, x_cur_next_s;
  logic [X_W:0]       x_end_r, x_end_next_s;
  logic [ADDR_W-1:0]  mem_addr_r, addr_next_s;
  logic [COLOR_W-1:0] mem_wdata_r, wdata_next_s;
  logic [X_W:0]       pix_count_r, pix_next_s;
  logic               mem_wr_req_r, busy_r, fill_done_r;

  logic [X_W:0]       x_left_wide_s;
  logic [X_W:0]       x_right_wide_s;
  logic [X_W:0]       x_end_clamp_s;
  logic               span_empty_s;

  // Clamp the right edge to the screen and decide whether the offered span is empty.
  always_comb begin
    x_left_wide_s  = {1'b0, x_left};
    x_right_wide_s = {1'b0, x_right};
    if (x_right_wide_s > X_LAST_C) begin
      x_end_clamp_s = X_LAST_C;
    end else begin
      x_end_clamp_s = x_right_wide_s;
    end
    span_empty_s = (!row_valid)
                 || (x_left_wide_s > x_end_clamp_s)
                 || (x_left_wide_s >= X_LIMIT_C)
                 || ({1'b0, row_y} >= Y_LIMIT_C);
  end

  // Next-state and datapath update; every value defaults to holding.
  always_comb begin
    state_next_s = state_r;
    y_next_s     = y_r;
    x_cur_next_s = x_cur_r;
    x_end_next_s = x_end_r;
    addr_next_s  = mem_addr_r;
    wdata_next_s = mem_wdata_r;
    pix_next_s   = pix_count_r;
    case (state_r)
      FR_IDLE: begin
        if (fill_start) begin
          y_next_s     = row_y;
          x_cur_next_s = x_left_wide_s;
          x_end_next_s = x_end_clamp_s;
          wdata_next_s = fill_color;
          pix_next_s   = '0;
          if (span_empty_s) begin
            state_next_s = FR_DONE;
          end else begin
            state_next_s = FR_SETUP;
          end
        end else begin
          state_next_s = FR_IDLE;
        end
      end
      FR_SETUP: begin
        // The only multiply: later pixels step the address by one.
        addr_next_s  = ADDR_W'(y_r) * ADDR_W'(SCREEN_W) + ADDR_W'(x_cur_r);
        state_next_s = FR_WRITE;
      end
      FR_WRITE: begin
        if (mem_ack) begin
          pix_next_s = pix_count_r + (X_W+1)'(1);
          if (x_cur_r == x_end_r) begin
            state_next_s = FR_DONE;
          end else begin
            x_cur_next_s = x_cur_r + (X_W+1)'(1);
            addr_next_s  = mem_addr_r + ADDR_W'(1);
            state_next_s = FR_WRITE;
          end
        end else begin
          state_next_s = FR_WRITE;
        end
      end
      FR_DONE: begin
        state_next_s = FR_IDLE;
      end
      default: begin
        state_next_s = FR_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons any span in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r      <= FR_IDLE;
      y_r          <= '0;
      x_cur_r      <= '0;
      x_end_r      <= '0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      pix_count_r  <= '0;
      mem_wr_req_r <= 1'b0;
      busy_r       <= 1'b0;
      fill_done_r  <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      y_r          <= y_next_s;
      x_cur_r      <= x_cur_next_s;
      x_end_r      <= x_end_next_s;
      mem_addr_r   <= addr_next_s;
      mem_wdata_r  <= wdata_next_s;
      pix_count_r  <= pix_next_s;
      mem_wr_req_r <= (state_next_s == FR_WRITE);
      busy_r       <= (state_next_s != FR_IDLE);
      fill_done_r  <= (state_next_s == FR_DONE);
    end
  end

  assign mem_wr_req = mem_wr_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign busy       = busy_r;
  assign fill_done  = fill_done_r;
  assign pix_count  = pix_count_r;

endmodule
